cart_mapper_multi: RTL

- Parametrised, mode-selectable MegaROM bank mapper for the MSX cartridge slot.
- One block replaces the per-mapper address generators (Konami, Konami SCC, ASCII8, ASCII16, plain ROM) behind the cartridge ROM wrapper.
- Holds four 8 KB bank registers and a per-page SRAM-select flag. Produces a registered, size-wrapped ROM address plus SRAM strobes for battery-backed ASCII carts.
- Sits between the slot decode (addr/wr/rd/cs) and the BRAM/SDRAM/SRAM back ends.

---
 rtl/cart_mapper_multi.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/cart_mapper_multi.sv
// cart_mapper_multi
//   Mode-selectable MegaROM bank mapper for the MSX cartridge slot. One block
//   covers plain ROM, Konami, Konami SCC, ASCII8 and ASCII16 carts. It keeps
//   four 8 KB bank registers plus a per-page SRAM-select flag, and it produces
//   a registered, size-wrapped ROM byte address and the SRAM strobes used by
//   battery-backed ASCII carts.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   mode              0 plain, 1 Konami, 2 Konami SCC, 3 ASCII8, 4 ASCII16
//                     (5-7 behave as plain)
//   rom_size          loaded image size in bytes, sets the address wrap mask
//   addr, d_from_cpu  CPU address and write data
//   wr, rd, cs        CPU write/read level strobes and slot select
//   mem_addr          ROM byte address (registered)
//   mem_valid         mem_addr refers to a mapped ROM page
//   sram_addr         SRAM byte address (registered)
//   sram_we           one-cycle SRAM write pulse
//   sram_oe           SRAM drives read data (registered)
module cart_mapper_multi #(
  parameter int          ADDR_W      = 25,
  parameter int          BANK_W      = 8,
  parameter int          SRAM_ADDR_W = 13,
  parameter logic [7:0]  SRAM_MASK   = 8'h20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             mode,
  input  logic [ADDR_W-1:0]      rom_size,
  input  logic [15:0]            addr,
  input  logic [7:0]             d_from_cpu,
  input  logic                   wr,
  input  logic                   rd,
  input  logic                   cs,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_valid,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   sram_we,
  output logic                   sram_oe
);

  localparam logic [2:0] M_PLAIN   = 3'd0;
  localparam logic [2:0] M_KONAMI  = 3'd1;
  localparam logic [2:0] M_SCC     = 3'd2;
  localparam logic [2:0] M_ASCII8  = 3'd3;
  localparam logic [2:0] M_ASCII16 = 3'd4;

  function automatic logic [2:0] eff_mode(input logic [2:0] m);
    return (m > M_ASCII16) ? M_PLAIN : m;
  endfunction

  // Konami carts boot with bank i mapped to page i; everything else boots at 0.
  function automatic logic [BANK_W-1:0] bank_init(input int i, input logic [2:0] m);
    logic [2:0] e;
    e = eff_mode(m);
    return (e == M_KONAMI || e == M_SCC) ? BANK_W'(i) : '0;
  endfunction

  logic [2:0]        mode_q;
  logic [BANK_W-1:0] bank [4];
  logic [3:0]        sram_en;
  logic              wr_d;

  logic [2:0]        cur_mode;
  logic              wstb;
  logic              page_ok;
  logic [1:0]        page;

  assign cur_mode = eff_mode(mode_q);
  assign wstb     = cs & wr & ~wr_d;
  assign page_ok  = (addr[15:14] == 2'b01) | (addr[15:14] == 2'b10);
  // addr[15:13] - 2 for the 4000-BFFF window, reduced to two bits
  assign page     = {~addr[14], addr[13]};

  // Register-window decode
  logic              hit;
  logic              pair;
  logic [1:0]        tgt;
  logic              is_ascii;
  logic              sram_sel;
  logic [BANK_W-1:0] d_ext;
  logic [BANK_W-1:0] v_lo;
  logic [BANK_W-1:0] v_hi;

  assign is_ascii = (cur_mode == M_ASCII8) | (cur_mode == M_ASCII16);
  assign sram_sel = is_ascii & ((d_from_cpu & SRAM_MASK) != 8'h00);
  assign d_ext    = BANK_W'(d_from_cpu);
  assign v_lo     = d_ext << 1;
  assign v_hi     = v_lo | BANK_W'(1);

  always_comb begin
    hit  = 1'b0;
    pair = 1'b0;
    tgt  = 2'd0;
    case (cur_mode)
      M_KONAMI: begin
        case (addr[15:13])
          3'd3: begin hit = 1'b1; tgt = 2'd1; end
          3'd4: begin hit = 1'b1; tgt = 2'd2; end
          3'd5: begin hit = 1'b1; tgt = 2'd3; end
          default: ;
        endcase
      end
      M_SCC: begin
        case (addr[15:11])
          5'h0A: begin hit = 1'b1; tgt = 2'd0; end
          5'h0E: begin hit = 1'b1; tgt = 2'd1; end
          5'h12: begin hit = 1'b1; tgt = 2'd2; end
          5'h16: begin hit = 1'b1; tgt = 2'd3; end
          default: ;
        endcase
      end
      M_ASCII8: begin
        if (addr[15:13] == 3'd3) begin
          hit = 1'b1;
          tgt = addr[12:11];
        end
      end
      M_ASCII16: begin
        if (addr[15:11] == 5'h0C) begin
          hit = 1'b1; pair = 1'b1; tgt = 2'd0;
        end else if (addr[15:11] == 5'h0E) begin
          hit = 1'b1; pair = 1'b1; tgt = 2'd2;
        end
      end
      default: ;
    endcase
  end

  // Wrap mask: smear (rom_size-1) right to get 2^k-1; sizes 0 and 1 map to 0.
  logic [ADDR_W-1:0] smear;
  logic [ADDR_W-1:0] mask;
  always_comb begin
    smear = rom_size - ADDR_W'(1);
    for (int s = 1; s < ADDR_W; s = s * 2)
      smear = smear | (smear >> s);
    mask = (rom_size <= ADDR_W'(1)) ? '0 : smear;
  end

  logic [15:0]       plain_off;
  logic [ADDR_W-1:0] raw;
  assign plain_off = addr - 16'h4000;
  assign raw = (cur_mode == M_PLAIN) ? ADDR_W'(plain_off)
                                     : ADDR_W'({bank[page], addr[12:0]});

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= mode;
      wr_d      <= 1'b0;
      sram_en   <= '0;
      for (int i = 0; i < 4; i++) bank[i] <= bank_init(i, mode);
      mem_addr  <= '0;
      mem_valid <= 1'b0;
      sram_addr <= '0;
      sram_we   <= 1'b0;
      sram_oe   <= 1'b0;
    end else begin
      mode_q <= mode;
      wr_d   <= wr;
      if (mode != mode_q) begin
        // new mapper type: reload its power-on banks, drop any write this cycle
        sram_en <= '0;
        for (int i = 0; i < 4; i++) bank[i] <= bank_init(i, mode);
      end else if (wstb && hit) begin
        if (pair) begin
          sram_en[tgt]           <= sram_sel;
          sram_en[{tgt[1], 1'b1}] <= sram_sel;
          if (!sram_sel) begin
            bank[tgt]            <= v_lo;
            bank[{tgt[1], 1'b1}] <= v_hi;
          end
        end else begin
          sram_en[tgt] <= sram_sel;
          if (!sram_sel) bank[tgt] <= d_ext;
        end
      end

      if (page_ok) begin
        mem_addr  <= raw & mask;
        mem_valid <= cs & ~sram_en[page];
      end else begin
        mem_valid <= 1'b0;
      end

      sram_addr <= addr[SRAM_ADDR_W-1:0];
      sram_oe   <= cs & rd & page_ok & sram_en[page];
      // only the upper two pages are writable SRAM
      sram_we   <= wstb & page_ok & sram_en[page] & page[1];
    end
  end

endmodule
